// File: rtl/wb_master_bridge_if.sv
// Command/response streams and Wishbone classic bus seen by wb_master_bridge.
// The master modport is the bridge's view; the slave modport is the environment's view.
interface wb_master_bridge_if #(
    parameter int unsigned ADR_W = 32,
    parameter int unsigned DAT_W = 32
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_we;
    logic [ADR_W-1:0]     cmd_adr;
    logic [DAT_W-1:0]     cmd_dat;
    logic [DAT_W/8-1:0]   cmd_sel;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DAT_W-1:0]     rsp_dat;
    logic                 rsp_err;
    logic                 rsp_timeout;

    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [DAT_W/8-1:0]   wb_sel;
    logic [ADR_W-1:0]     adr;
    logic [DAT_W-1:0]     dat_mosi;
    logic [DAT_W-1:0]     dat_miso;
    logic                 ack;
    logic                 err;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, dat_miso, ack, err,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err, rsp_timeout,
               cyc, stb, we, wb_sel, adr, dat_mosi
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, dat_miso, ack, err,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err, rsp_timeout,
               cyc, stb, we, wb_sel, adr, dat_mosi
    );
endinterface

// File: rtl/wb_master_bridge.sv
// Single-outstanding Wishbone classic initiator: one command in, one bus cycle,
// one response out, with a watchdog that aborts cycles a responder never ends.
module wb_master_bridge #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned ADR_W   = 32,
    parameter int unsigned DAT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    wb_master_bridge_if.master bus
);
    localparam int unsigned SEL_W = DAT_W / 8;
    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t             state_q, state_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_timeout_q, rsp_timeout_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic               we_q, we_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [DAT_W-1:0]   mosi_q, mosi_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // State and every output register; reset is synchronous, active low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_dat_q     <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cyc_q         <= 1'b0;
            stb_q         <= 1'b0;
            we_q          <= 1'b0;
            sel_q         <= '0;
            adr_q         <= '0;
            mosi_q        <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_dat_q     <= rsp_dat_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cyc_q         <= cyc_d;
            stb_q         <= stb_d;
            we_q          <= we_d;
            sel_q         <= sel_d;
            adr_q         <= adr_d;
            mosi_q        <= mosi_d;
            cnt_q         <= cnt_d;
        end
    end

    // Next state and next register values; everything holds unless changed.
    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_dat_d     = rsp_dat_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cyc_d         = cyc_q;
        stb_d         = stb_q;
        we_d          = we_q;
        sel_d         = sel_q;
        adr_d         = adr_q;
        mosi_d        = mosi_q;
        cnt_d         = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    we_d        = bus.cmd_we;
                    adr_d       = bus.cmd_adr;
                    mosi_d      = bus.cmd_dat;
                    sel_d       = bus.cmd_sel;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    cmd_ready_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = BUS;
                end
            end
            BUS: begin
                // err takes priority over a simultaneous ack
                if (bus.err) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (bus.ack) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = we_q ? '0 : bus.dat_miso;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    cyc_d         = 1'b0;
                    stb_d         = 1'b0;
                    rsp_timeout_d = 1'b1;
                    rsp_dat_d     = '0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d   = 1'b0;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                    cmd_ready_d   = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_dat     = rsp_dat_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.cyc         = cyc_q;
    assign bus.stb         = stb_q;
    assign bus.we          = we_q;
    assign bus.wb_sel      = sel_q;
    assign bus.adr         = adr_q;
    assign bus.dat_mosi    = mosi_q;
endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge: one instance with TIMEOUT=8 behind a
// scriptable responder, one with TIMEOUT=0 behind a responder that never answers.
module tb_wb_master_bridge;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_master_bridge_if #(.ADR_W(32), .DAT_W(32)) ia ();
    wb_master_bridge_if #(.ADR_W(32), .DAT_W(32)) ib ();

    wb_master_bridge #(.TIMEOUT(8), .ADR_W(32), .DAT_W(32)) u_dut (
        .clk(clk), .rst(rst), .bus(ia.master)
    );
    wb_master_bridge #(.TIMEOUT(0), .ADR_W(32), .DAT_W(32)) u_dut0 (
        .clk(clk), .rst(rst), .bus(ib.master)
    );

    int vectors = 0;
    int miscompares = 0;

    // Responder for ia: 0 zero-wait register file, 1 three wait states with a
    // fixed word, 2 err+ack on the second bus cycle, 3 silent.
    int          mode = 0;
    logic        stray_ack = 1'b0;
    logic [31:0] mem [16];
    int          wcnt = 0;

    always @(posedge clk) begin
        if (ia.cyc && ia.stb && !(ia.ack || ia.err)) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (ia.cyc && ia.stb && ia.ack && !ia.err && ia.we) begin
            for (int b = 0; b < 4; b++)
                if (ia.wb_sel[b]) mem[ia.adr[5:2]][b*8 +: 8] <= ia.dat_mosi[b*8 +: 8];
        end
    end

    always_comb begin
        ia.ack = stray_ack ||
                 (ia.cyc && ia.stb && (mode == 0 || (mode == 1 && wcnt == 3) || (mode == 2 && wcnt == 1)));
        ia.err = ia.cyc && ia.stb && mode == 2 && wcnt == 1;
        ia.dat_miso = (mode == 1) ? 32'h1234_5678 : mem[ia.adr[5:2]];
    end

    assign ib.ack       = 1'b0;
    assign ib.err       = 1'b0;
    assign ib.dat_miso  = 32'h0;
    assign ib.rsp_ready = 1'b1;

    // Runs one command on ia with rsp_ready held 1; reports cycles with cyc high
    // (-1 if never accepted), the response seen, and whether bus fields stayed put.
    task automatic do_txn(input logic twe, input logic [31:0] tadr, input logic [31:0] tdat,
                          input logic [3:0] tsel, output int ncyc, output logic rv,
                          output logic [31:0] rdat, output logic rerr, output logic rtmo,
                          output logic [31:0] seen_mosi, output logic [3:0] seen_sel,
                          output logic held);
        int guard;
        @(negedge clk);
        ia.cmd_valid = 1'b1; ia.cmd_we = twe; ia.cmd_adr = tadr;
        ia.cmd_dat = tdat; ia.cmd_sel = tsel;
        guard = 0;
        while (!ia.cmd_ready && guard < 20) begin @(negedge clk); guard++; end
        @(posedge clk);
        @(negedge clk);
        ia.cmd_valid = 1'b0;
        seen_mosi = ia.dat_mosi; seen_sel = ia.wb_sel; held = 1'b1; ncyc = 0;
        while (ia.cyc && ncyc < 100) begin
            if (ia.dat_mosi !== seen_mosi || ia.wb_sel !== seen_sel || ia.we !== twe ||
                ia.adr !== tadr || ia.stb !== 1'b1) held = 1'b0;
            ncyc++;
            @(negedge clk);
        end
        if (guard >= 20) ncyc = -1;
        rv = ia.rsp_valid; rdat = ia.rsp_dat; rerr = ia.rsp_err; rtmo = ia.rsp_timeout;
        @(negedge clk);
    endtask

    int ncyc;
    logic rv, rerr, rtmo, held;
    logic [31:0] rdat, smosi;
    logic [3:0] ssel;

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({ia.cmd_ready, ia.rsp_valid, ia.rsp_err, ia.rsp_timeout, ia.cyc, ia.stb, ia.we} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 1000000",
                     {ia.cmd_ready, ia.rsp_valid, ia.rsp_err, ia.rsp_timeout, ia.cyc, ia.stb, ia.we});
        end
        vectors++;
        if ({ia.rsp_dat, ia.wb_sel, ia.adr, ia.dat_mosi} !== 100'h0) begin
            miscompares++;
            $display("FAIL reset_data got dat=%h sel=%h adr=%h mosi=%h want all 0",
                     ia.rsp_dat, ia.wb_sel, ia.adr, ia.dat_mosi);
        end
        rst = 1'b1;
    endtask

    task automatic test_zero_wait_write();
        mode = 0;
        do_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, ncyc, rv, rdat, rerr, rtmo, smosi, ssel, held);
        vectors++;
        if (ncyc !== 1) begin miscompares++; $display("FAIL zw_write_cyc got %0d want 1", ncyc); end
        vectors++;
        if ({smosi, ssel, held} !== {32'hDEAD_BEEF, 4'hF, 1'b1}) begin
            miscompares++;
            $display("FAIL zw_write_bus got mosi=%h sel=%h held=%b want DEADBEEF F 1", smosi, ssel, held);
        end
        vectors++;
        if ({rv, rdat, rerr, rtmo} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL zw_write_rsp got v=%b dat=%h err=%b tmo=%b want 1 0 0 0", rv, rdat, rerr, rtmo);
        end
        vectors++;
        if ({ia.rsp_valid, ia.cmd_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL zw_write_idle got valid=%b ready=%b want 0 1", ia.rsp_valid, ia.cmd_ready);
        end
    endtask

    task automatic test_read_after_write();
        mode = 0;
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, ncyc, rv, rdat, rerr, rtmo, smosi, ssel, held);
        vectors++;
        if ({ncyc == 1, rv, rdat, rerr} !== {1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0}) begin
            miscompares++;
            $display("FAIL raw_read got cyc=%0d v=%b dat=%h err=%b want 1 1 DEADBEEF 0", ncyc, rv, rdat, rerr);
        end
        do_txn(1'b1, 32'h10, 32'h0000_00AA, 4'h1, ncyc, rv, rdat, rerr, rtmo, smosi, ssel, held);
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, ncyc, rv, rdat, rerr, rtmo, smosi, ssel, held);
        vectors++;
        if (rdat !== 32'hDEAD_BEAA) begin
            miscompares++;
            $display("FAIL byte_sel_read got %h want DEADBEAA", rdat);
        end
        mode = 1;
        do_txn(1'b0, 32'h40, 32'h0, 4'hF, ncyc, rv, rdat, rerr, rtmo, smosi, ssel, held);
        vectors++;
        if (ncyc !== 4) begin miscompares++; $display("FAIL wait3_cyc got %0d want 4", ncyc); end
        vectors++;
        if ({rv, rdat, rerr, rtmo, held} !== {1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL wait3_rsp got v=%b dat=%h err=%b tmo=%b held=%b want 1 12345678 0 0 1",
                     rv, rdat, rerr, rtmo, held);
        end
    endtask

    task automatic test_err();
        mode = 2;
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, ncyc, rv, rdat, rerr, rtmo, smosi, ssel, held);
        vectors++;
        if (ncyc !== 2) begin miscompares++; $display("FAIL err_cyc got %0d want 2", ncyc); end
        vectors++;
        if ({rv, rdat, rerr, rtmo} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL err_rsp got v=%b dat=%h err=%b tmo=%b want 1 0 1 0", rv, rdat, rerr, rtmo);
        end
    endtask

    task automatic test_timeout();
        mode = 3;
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, ncyc, rv, rdat, rerr, rtmo, smosi, ssel, held);
        vectors++;
        if (ncyc !== 8) begin miscompares++; $display("FAIL tmo_cyc got %0d want 8", ncyc); end
        vectors++;
        if ({rv, rdat, rerr, rtmo} !== {1'b1, 32'h0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL tmo_rsp got v=%b dat=%h err=%b tmo=%b want 1 0 0 1", rv, rdat, rerr, rtmo);
        end
        mode = 0;
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, ncyc, rv, rdat, rerr, rtmo, smosi, ssel, held);
        vectors++;
        if ({ncyc == 1, rv, rdat, rerr, rtmo} !== {1'b1, 1'b1, 32'hDEAD_BEAA, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL post_tmo_read got cyc=%0d v=%b dat=%h err=%b tmo=%b want 1 1 DEADBEAA 0 0",
                     ncyc, rv, rdat, rerr, rtmo);
        end
    endtask

    task automatic test_stray_ack();
        mode = 0;
        @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        stray_ack = 1'b0;
        vectors++;
        if ({ia.rsp_valid, ia.cyc, ia.cmd_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL stray_ack got valid=%b cyc=%b ready=%b want 0 0 1", ia.rsp_valid, ia.cyc, ia.cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        mode = 0;
        @(negedge clk);
        ia.rsp_ready = 1'b0;
        ia.cmd_valid = 1'b1; ia.cmd_we = 1'b1; ia.cmd_adr = 32'h20;
        ia.cmd_dat = 32'h1111_1111; ia.cmd_sel = 4'hF;
        @(posedge clk);
        @(negedge clk);
        ia.cmd_we = 1'b0; ia.cmd_adr = 32'h20; ia.cmd_dat = 32'h0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({ia.rsp_valid, ia.rsp_dat, ia.rsp_err, ia.cmd_ready, ia.cyc} !== {1'b1, 32'h0, 1'b0, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL bp_hold[%0d] got v=%b dat=%h err=%b ready=%b cyc=%b want 1 0 0 0 0",
                         i, ia.rsp_valid, ia.rsp_dat, ia.rsp_err, ia.cmd_ready, ia.cyc);
            end
            if (i < 4) @(negedge clk);
        end
        ia.rsp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ia.rsp_valid, ia.cmd_ready, ia.cyc} !== 3'b010) begin
            miscompares++;
            $display("FAIL bp_release got v=%b ready=%b cyc=%b want 0 1 0", ia.rsp_valid, ia.cmd_ready, ia.cyc);
        end
        @(negedge clk);
        ia.cmd_valid = 1'b0;
        vectors++;
        if ({ia.cyc, ia.we, ia.adr} !== {1'b1, 1'b0, 32'h20}) begin
            miscompares++;
            $display("FAIL bp_second_cmd got cyc=%b we=%b adr=%h want 1 0 00000020", ia.cyc, ia.we, ia.adr);
        end
        @(negedge clk);
        vectors++;
        if ({ia.rsp_valid, ia.rsp_dat, ia.rsp_err} !== {1'b1, 32'h1111_1111, 1'b0}) begin
            miscompares++;
            $display("FAIL bp_second_rsp got v=%b dat=%h err=%b want 1 11111111 0", ia.rsp_valid, ia.rsp_dat, ia.rsp_err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_bus();
        mode = 3;
        @(negedge clk);
        ia.cmd_valid = 1'b1; ia.cmd_we = 1'b1; ia.cmd_adr = 32'h30;
        ia.cmd_dat = 32'h5555_5555; ia.cmd_sel = 4'hF;
        @(posedge clk);
        @(negedge clk);
        ia.cmd_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (ia.cyc !== 1'b1) begin miscompares++; $display("FAIL mid_bus_pre got cyc=%b want 1", ia.cyc); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        vectors++;
        if ({ia.cyc, ia.stb, ia.rsp_valid, ia.cmd_ready, ia.we, ia.wb_sel, ia.adr, ia.dat_mosi} !==
            {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL mid_bus_reset got cyc=%b stb=%b v=%b ready=%b we=%b sel=%h adr=%h mosi=%h want 0 0 0 1 0 0 0 0",
                     ia.cyc, ia.stb, ia.rsp_valid, ia.cmd_ready, ia.we, ia.wb_sel, ia.adr, ia.dat_mosi);
        end
        mode = 0;
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, ncyc, rv, rdat, rerr, rtmo, smosi, ssel, held);
        vectors++;
        if ({ncyc == 1, rv, rdat} !== {1'b1, 1'b1, 32'hDEAD_BEAA}) begin
            miscompares++;
            $display("FAIL post_reset_read got cyc=%0d v=%b dat=%h want 1 1 DEADBEAA", ncyc, rv, rdat);
        end
    endtask

    task automatic test_no_watchdog();
        logic dropped;
        @(negedge clk);
        ib.cmd_valid = 1'b1; ib.cmd_we = 1'b0; ib.cmd_adr = 32'h4;
        ib.cmd_dat = 32'h0; ib.cmd_sel = 4'hF;
        @(posedge clk);
        @(negedge clk);
        ib.cmd_valid = 1'b0;
        dropped = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (!(ib.cyc && ib.stb) || ib.rsp_valid) dropped = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (dropped !== 1'b0) begin
            miscompares++;
            $display("FAIL no_watchdog got dropped=%b want 0 over 1000 cycles", dropped);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        vectors++;
        if ({ib.cyc, ib.cmd_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL no_watchdog_reset got cyc=%b ready=%b want 0 1", ib.cyc, ib.cmd_ready);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        ia.cmd_valid = 1'b0; ia.cmd_we = 1'b0; ia.cmd_adr = 32'h0; ia.cmd_dat = 32'h0;
        ia.cmd_sel = 4'h0; ia.rsp_ready = 1'b1;
        ib.cmd_valid = 1'b0; ib.cmd_we = 1'b0; ib.cmd_adr = 32'h0; ib.cmd_dat = 32'h0;
        ib.cmd_sel = 4'h0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_zero_wait_write();
        test_read_after_write();
        test_err();
        test_timeout();
        test_stray_ack();
        test_back_to_back();
        test_reset_mid_bus();
        test_no_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no completion want finish before 200000ns");
        $fatal(1, "bench did not complete");
    end
endmodule
